// File: rtl/kiwi_axil_mem.sv
// rtl/kiwi_axil_mem.sv - AXI-lite responder memory with byte-strobed writes and programmable read latency
module kiwi_axil_mem #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          DEPTH     = 65536,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    input  logic [63:0] awaddr,
    input  logic [2:0]  awprot,
    output logic        awready,
    input  logic        wvalid,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        wready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    input  logic        bready,
    input  logic        arvalid,
    input  logic [63:0] araddr,
    input  logic [2:0]  arprot,
    output logic        arready,
    output logic        rvalid,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    input  logic        rready
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    typedef enum logic       {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [63:0] mem_q [DEPTH];

    // ---------------- write side ----------------
    w_state_t    w_state_q, w_state_d;
    logic        aw_have_q, aw_have_d;
    logic        w_have_q, w_have_d;
    logic [63:0] awaddr_q, awaddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic             aw_hs, w_hs, wr_commit, wr_in_range;
    logic [63:0]      wr_addr, wr_data, wr_off;
    logic [7:0]       wr_strb;
    logic [IDX_W-1:0] wr_idx;

    assign awready = !rst && (w_state_q == W_IDLE) && !aw_have_q;
    assign wready  = !rst && (w_state_q == W_IDLE) && !w_have_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // The channel completing on this edge is taken straight from the bus so the
    // write commits on the same edge as the last handshake.
    assign wr_addr     = aw_have_q ? awaddr_q : awaddr;
    assign wr_data     = w_have_q ? wdata_q : wdata;
    assign wr_strb     = w_have_q ? wstrb_q : wstrb;
    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = (wr_addr >= BASE_ADDR) && (wr_off < SPAN);
    assign wr_idx      = wr_off[IDX_W+2:3];
    assign wr_commit   = (w_state_q == W_IDLE) && (aw_have_q || aw_hs) && (w_have_q || w_hs);

    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_have_d = 1'b1;
                    awaddr_d  = awaddr;
                end
                if (w_hs) begin
                    w_have_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (wr_commit) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_in_range ? 2'b00 : 2'b10;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit && wr_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;

    // ---------------- read side ----------------
    r_state_t    r_state_q, r_state_d;
    logic [2:0]  rcnt_q, rcnt_d;
    logic [63:0] araddr_q, araddr_d;
    logic        rvalid_q, rvalid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic             ar_hs, rd_in_range, rd_sample;
    logic [63:0]      rd_addr, rd_off, rd_word;
    logic [IDX_W-1:0] rd_idx;

    assign arready     = !rst && (r_state_q == R_IDLE);
    assign ar_hs       = arvalid && arready;
    assign rd_addr     = (r_state_q == R_IDLE) ? araddr : araddr_q;
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = (rd_addr >= BASE_ADDR) && (rd_off < SPAN);
    assign rd_idx      = rd_off[IDX_W+2:3];
    // Reads the registered array, so a same-edge write is not yet visible.
    assign rd_word     = rd_in_range ? mem_q[rd_idx] : 64'd0;

    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        araddr_d  = araddr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_sample = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    araddr_d = araddr;
                    if (RD_LAT <= 1) begin
                        rd_sample = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                        rcnt_d    = 3'(RD_LAT - 1);
                    end
                end
            end
            R_WAIT: begin
                rcnt_d = rcnt_q - 3'd1;
                if (rcnt_q <= 3'd1) begin
                    rd_sample = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_sample) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rdata_d   = rd_word;
            rresp_d   = rd_in_range ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rcnt_q    <= 3'd0;
            araddr_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            rcnt_q    <= rcnt_d;
            araddr_q  <= araddr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, wr_off[2:0], wr_off[63:IDX_W+3],
                           rd_off[2:0], rd_off[63:IDX_W+3]};

endmodule

// File: tb/tb_kiwi_axil_mem.sv
// tb/tb_kiwi_axil_mem.sv - directed self-checking bench for kiwi_axil_mem
module tb_kiwi_axil_mem;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 65536;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [63:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [7:0]  wstrb = '0;
    logic [2:0]  awprot = '0, arprot = '0;

    logic        awready1, wready1, bvalid1, arready1, rvalid1;
    logic [1:0]  bresp1, rresp1;
    logic [63:0] rdata1;
    logic        awready3, wready3, bvalid3, arready3, rvalid3;
    logic [1:0]  bresp3, rresp3;
    logic [63:0] rdata3;

    kiwi_axil_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready1),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready1),
        .bvalid(bvalid1), .bresp(bresp1), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready1),
        .rvalid(rvalid1), .rdata(rdata1), .rresp(rresp1), .rready(rready)
    );

    kiwi_axil_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready3),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready3),
        .bvalid(bvalid3), .bresp(bresp3), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready3),
        .rvalid(rvalid3), .rdata(rdata3), .rresp(rresp3), .rready(rready)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 20 && !(arready1 && arready3 && awready1 && awready3); i++) tick;
        if (!(arready1 && arready3 && awready1 && awready3)) check("idle_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp);
        bit aw_done, w_done, got;
        aw_done = 0; w_done = 0; got = 0;
        resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 16 && !(aw_done && w_done); i++) begin
            if (awready1) aw_done = 1;
            if (wready1)  w_done  = 1;
            tick;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (bvalid1) begin
                got  = 1;
                resp = bresp1;
            end
            tick;
        end
        if (!got) check("b_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
        bit got;
        got = 0;
        d = '1; resp = 2'b11;
        wait_idle;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick;
        arvalid = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (rvalid1) begin
                got  = 1;
                d    = rdata1;
                resp = rresp1;
            end
            tick;
        end
        if (!got) check("r_timeout", 0, 1);
        wait_idle;
    endtask

    logic [1:0]  resp;
    logic [63:0] rd;

    initial begin
        // Reset with random valids
        for (int i = 0; i < 3; i++) begin
            awvalid = 1'($urandom); wvalid = 1'($urandom); arvalid = 1'($urandom);
            bready = 1'($urandom); rready = 1'($urandom);
            awaddr = BASE; araddr = BASE;
            tick;
            check("rst_readies", {awready1, wready1, arready1}, 3'b000);
            check("rst_valids", {bvalid1, rvalid1, bresp1, rresp1}, 6'b0);
            check("rst_rdata", rdata1, 64'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        rst = 1'b0;
        #1;
        check("post_rst_readies", {awready1, wready1, arready1}, 3'b111);

        // Write then strobed partial write, read back
        do_write(BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, resp);
        check("wr_full_bresp", resp, 2'b00);
        do_write(BASE + 64'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, resp);
        check("wr_strb_bresp", resp, 2'b00);
        do_read(BASE + 64'h10, rd, resp);
        check("rd_strb_data", rd, 64'h1122_3344_BBBB_BBBB);
        check("rd_strb_rresp", resp, 2'b00);

        // W four cycles ahead of AW, bready stalled 5 cycles
        wait_idle;
        bready = 1'b0;
        wvalid = 1'b1; wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF;
        check("ord_wready0", wready1, 1'b1);
        tick;
        wvalid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("ord_wready_low", wready1, 1'b0);
            check("ord_awready_hi", awready1, 1'b1);
            check("ord_bvalid_lo", bvalid1, 1'b0);
            tick;
        end
        awvalid = 1'b1; awaddr = BASE + 64'h20;
        check("ord_awready4", awready1, 1'b1);
        tick;
        awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ord_bvalid_hold", {bvalid1, bresp1}, 3'b100);
            check("ord_readies_lo", {awready1, wready1}, 2'b00);
            tick;
        end
        bready = 1'b1;
        check("ord_bvalid_hs", bvalid1, 1'b1);
        tick;
        check("ord_bvalid_clr", bvalid1, 1'b0);
        check("ord_readies_back", {awready1, wready1}, 2'b11);
        do_read(BASE + 64'h20, rd, resp);
        check("ord_rdata", rd, 64'h0123_4567_89AB_CDEF);

        // Out-of-range below and above the window, neighbours intact
        do_write(BASE, 64'h5, 8'hFF, resp);
        do_write(BASE + 64'(DEPTH) * 8 - 8, 64'hCAFE, 8'hFF, resp);
        do_write(64'h7FFF_FFF8, 64'hDEAD_BEEF, 8'hFF, resp);
        check("oor_lo_bresp", resp, 2'b10);
        do_read(64'h7FFF_FFF8, rd, resp);
        check("oor_lo_rresp", resp, 2'b10);
        check("oor_lo_rdata", rd, 64'd0);
        do_write(BASE + 64'(DEPTH) * 8, 64'hDEAD_BEEF, 8'hFF, resp);
        check("oor_hi_bresp", resp, 2'b10);
        do_read(BASE + 64'(DEPTH) * 8, rd, resp);
        check("oor_hi_rresp", resp, 2'b10);
        check("oor_hi_rdata", rd, 64'd0);
        do_read(BASE + 64'(DEPTH) * 8 - 8, rd, resp);
        check("oor_last_word", rd, 64'hCAFE);
        do_read(BASE, rd, resp);
        check("oor_word0", rd, 64'h5);

        // RD_LAT=3 instance with rready stalled 2 cycles
        wait_idle;
        araddr = BASE + 64'h10; arvalid = 1'b1; rready = 1'b0;
        check("lat3_arready_n", arready3, 1'b1);
        tick;
        arvalid = 1'b0;
        check("lat1_rvalid_n1", rvalid1, 1'b1);
        check("lat1_rdata_n1", rdata1, 64'h1122_3344_BBBB_BBBB);
        check("lat3_rvalid_n1", rvalid3, 1'b0);
        check("lat3_arready_n1", arready3, 1'b0);
        tick;
        check("lat3_rvalid_n2", rvalid3, 1'b0);
        check("lat3_arready_n2", arready3, 1'b0);
        tick;
        check("lat3_rvalid_n3", rvalid3, 1'b1);
        check("lat3_rdata_n3", rdata3, 64'h1122_3344_BBBB_BBBB);
        tick;
        check("lat3_rvalid_n4", rvalid3, 1'b1);
        check("lat3_rdata_n4", rdata3, 64'h1122_3344_BBBB_BBBB);
        check("lat3_arready_n4", arready3, 1'b0);
        rready = 1'b1;
        tick;
        check("lat3_rvalid_clr", rvalid3, 1'b0);
        check("lat3_arready_back", arready3, 1'b1);

        // Write commit and read sample on the same edge
        wait_idle;
        awvalid = 1'b1; awaddr = BASE; wvalid = 1'b1; wdata = 64'h9; wstrb = 8'hFF;
        arvalid = 1'b1; araddr = BASE; bready = 1'b1; rready = 1'b1;
        check("col_readies", {awready1, wready1, arready1}, 3'b111);
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("col_bvalid", bvalid1, 1'b1);
        check("col_rvalid", rvalid1, 1'b1);
        check("col_rdata_old", rdata1, 64'h5);
        tick;
        do_read(BASE, rd, resp);
        check("col_rdata_new", rd, 64'h9);

        // Reset in the middle of a read drops it
        wait_idle;
        araddr = BASE; arvalid = 1'b1; rready = 1'b0;
        tick;
        arvalid = 1'b0;
        rst = 1'b1;
        tick;
        check("midrst_rvalid", {rvalid1, rvalid3}, 2'b00);
        check("midrst_rdata", rdata1, 64'd0);
        check("midrst_arready", {arready1, arready3}, 2'b00);
        rst = 1'b0; rready = 1'b1;
        #1;
        check("midrst_release", {arready1, arready3, awready1, wready1}, 4'b1111);
        tick;
        check("midrst_no_resp", {rvalid1, rvalid3}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
